// File: rtl/pwr_cntr_bank.sv
// Bank of per-channel toggle counters with sequential clear and one-cycle read port.
// Define PWR_CNTR_SAT_EN to make counters saturate at all-ones instead of wrapping.
module pwr_cntr_bank #(
  parameter int unsigned NCH = 5,
  parameter int unsigned AW  = 3,
  parameter int unsigned CW  = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ENB,
  input  logic [NCH-1:0]  SIG,
  input  logic            CLR,
  input  logic            RD_REQ,
  input  logic [AW-1:0]   RD_DIR,
  output logic [CW-1:0]   RD_DATO,
  output logic            RD_ACK,
  output logic            BUSY,
  output logic [NCH-1:0]  OVF
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [CW-1:0] CntMax  = {CW{1'b1}};
  localparam logic [AW-1:0] LastIdx = AW'(NCH - 1);

  state_e          state_q;
  logic [AW-1:0]   clr_idx_q;
  logic [NCH-1:0]  sig_prev_q;
  logic [NCH-1:0]  ovf_q;
  logic [CW-1:0]   cnt_q [NCH];
  logic            rd_ack_q;
  logic [CW-1:0]   rd_dato_q;
  logic [NCH-1:0]  toggle;
  logic [CW-1:0]   rd_sel;

  assign toggle = SIG ^ sig_prev_q;

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (RD_DIR == AW'(i)) rd_sel = cnt_q[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      clr_idx_q  <= '0;
      sig_prev_q <= '0;
      ovf_q      <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sig_prev_q <= SIG;
      unique case (state_q)
        StIdle: begin
          if (ENB) begin
            for (int i = 0; i < NCH; i++) begin
              if (toggle[i]) begin
                if (cnt_q[i] == CntMax) begin
                  ovf_q[i] <= 1'b1;
`ifdef PWR_CNTR_SAT_EN
                  cnt_q[i] <= CntMax;
`else
                  cnt_q[i] <= '0;
`endif
                end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
                end
              end
            end
          end
          if (CLR) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
          end
        end
        StClear: begin
          for (int i = 0; i < NCH; i++) begin
            if (clr_idx_q == AW'(i)) begin
              cnt_q[i] <= '0;
              ovf_q[i] <= 1'b0;
            end
          end
          if (clr_idx_q == LastIdx) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  // Read data reflects the counter before any same-cycle update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ack_q  <= 1'b0;
      rd_dato_q <= '0;
    end else begin
      rd_ack_q  <= RD_REQ;
      rd_dato_q <= RD_REQ ? rd_sel : '0;
    end
  end

  assign RD_ACK  = rd_ack_q;
  assign RD_DATO = rd_dato_q;
  assign BUSY    = (state_q == StClear);
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_pwr_cntr_bank.sv
// Directed bench for pwr_cntr_bank: vector table plus hand-written clear/reset/overflow sequences.
// A second narrow-counter instance exercises overflow with the same PWR_CNTR_SAT_EN setting.
module tb_pwr_cntr_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enb = 1'b0;
  logic [4:0]  sig = '0;
  logic        clr = 1'b0;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_dir = '0;
  logic [31:0] rd_dato;
  logic        rd_ack;
  logic        busy;
  logic [4:0]  ovf;

  logic [4:0]  o_sig = '0;
  logic        o_clr = 1'b0;
  logic        o_rd_req = 1'b0;
  logic [2:0]  o_rd_dir = '0;
  logic [3:0]  o_rd_dato;
  logic        o_rd_ack;
  logic        o_busy;
  logic [4:0]  o_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwr_cntr_bank #(.NCH(5), .AW(3), .CW(32)) dut (
    .CLK(clk), .RST(rst), .ENB(enb), .SIG(sig), .CLR(clr), .RD_REQ(rd_req),
    .RD_DIR(rd_dir), .RD_DATO(rd_dato), .RD_ACK(rd_ack), .BUSY(busy), .OVF(ovf)
  );

  pwr_cntr_bank #(.NCH(5), .AW(3), .CW(4)) u_ovf (
    .CLK(clk), .RST(rst), .ENB(1'b1), .SIG(o_sig), .CLR(o_clr), .RD_REQ(o_rd_req),
    .RD_DIR(o_rd_dir), .RD_DATO(o_rd_dato), .RD_ACK(o_rd_ack), .BUSY(o_busy), .OVF(o_ovf)
  );

  typedef struct {
    logic [4:0]  sig;
    logic        enb;
    logic        rd_req;
    logic [2:0]  dir;
    logic        ack;
    logic [31:0] dato;
  } vec_t;

  vec_t vecs[$];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] dir, input logic [31:0] exp, input string name);
    rd_req = 1'b1;
    rd_dir = dir;
    step;
    chk({name, " ack"}, 32'(rd_ack), 32'd1);
    chk({name, " data"}, rd_dato, exp);
    rd_req = 1'b0;
    step;
    chk({name, " ack drop"}, 32'(rd_ack), 32'd0);
    chk({name, " data idle"}, rd_dato, 32'd0);
  endtask

  task automatic ord(input logic [2:0] dir, input logic [3:0] exp, input string name);
    o_rd_req = 1'b1;
    o_rd_dir = dir;
    step;
    chk({name, " ack"}, 32'(o_rd_ack), 32'd1);
    chk({name, " data"}, 32'(o_rd_dato), 32'(exp));
    o_rd_req = 1'b0;
    step;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sig = '0;
    o_sig = '0;
    step;
    step;
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] s;
    logic [3:0] exp_sat1, exp_sat2;

    // Reset state, checked while reset is held.
    #1 rst = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ack", 32'(rd_ack), 32'd0);
    chk("reset data", rd_dato, 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    step;
    step;
    rst = 1'b0;

    // 10 toggles on ch0, then 6 disabled + 4 enabled toggles on ch1, then reads.
    s = '0;
    for (int k = 0; k < 10; k++) begin
      s[0] = ~s[0];
      vecs.push_back('{s, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0});
    end
    vecs.push_back('{s, 1'b1, 1'b1, 3'd0, 1'b1, 32'd10});
    vecs.push_back('{s, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0});
    for (int k = 0; k < 6; k++) begin
      s[1] = ~s[1];
      vecs.push_back('{s, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0});
    end
    for (int k = 0; k < 4; k++) begin
      s[1] = ~s[1];
      vecs.push_back('{s, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0});
    end
    vecs.push_back('{s, 1'b1, 1'b1, 3'd1, 1'b1, 32'd4});
    vecs.push_back('{s, 1'b1, 1'b1, 3'd0, 1'b1, 32'd10});
    vecs.push_back('{s, 1'b1, 1'b1, 3'd5, 1'b1, 32'd0});
    vecs.push_back('{s, 1'b1, 1'b1, 3'd7, 1'b1, 32'd0});
    vecs.push_back('{s, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0});

    for (int k = 0; k < vecs.size(); k++) begin
      sig    = vecs[k].sig;
      enb    = vecs[k].enb;
      rd_req = vecs[k].rd_req;
      rd_dir = vecs[k].dir;
      step;
      chk($sformatf("vec%0d ack", k), 32'(rd_ack), 32'(vecs[k].ack));
      chk($sformatf("vec%0d data", k), rd_dato, vecs[k].dato);
    end
    chk("no ovf after table", 32'(ovf), 32'd0);

    // Counts {3,5,7,9,11} loaded in parallel.
    do_reset;
    enb = 1'b1;
    for (int t = 0; t < 11; t++) begin
      for (int i = 0; i < 5; i++) if (t < 3 + 2 * i) sig[i] = ~sig[i];
      step;
    end
    for (int i = 0; i < 5; i++) rd(3'(i), 32'(3 + 2 * i), $sformatf("load ch%0d", i));

    // Clear sequence: 5 busy cycles, second CLR ignored, reads during CLEAR.
    clr = 1'b1;
    step;
    chk("clr c1 busy", 32'(busy), 32'd1);
    clr = 1'b0;
    step;
    chk("clr c2 busy", 32'(busy), 32'd1);
    clr = 1'b1;
    step;
    chk("clr c3 busy", 32'(busy), 32'd1);
    clr = 1'b0;
    rd_req = 1'b1;
    rd_dir = 3'd0;
    step;
    chk("clr c4 busy", 32'(busy), 32'd1);
    chk("clr rd ch0 ack", 32'(rd_ack), 32'd1);
    chk("clr rd ch0 data", rd_dato, 32'd0);
    rd_dir = 3'd4;
    step;
    chk("clr c5 busy", 32'(busy), 32'd1);
    chk("clr rd ch4 data", rd_dato, 32'd11);
    rd_req = 1'b0;
    step;
    chk("clr done busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("clr no restart %0d", k), 32'(busy), 32'd0);
    end
    for (int i = 0; i < 5; i++) rd(3'(i), 32'd0, $sformatf("cleared ch%0d", i));
    chk("cleared ovf", 32'(ovf), 32'd0);

    // Read coinciding with increment returns pre-increment value.
    for (int k = 0; k < 7; k++) begin
      sig[3] = ~sig[3];
      step;
    end
    sig[3] = ~sig[3];
    rd_req = 1'b1;
    rd_dir = 3'd3;
    step;
    chk("coincide ack", 32'(rd_ack), 32'd1);
    chk("coincide data", rd_dato, 32'd7);
    step;
    chk("next read ack", 32'(rd_ack), 32'd1);
    chk("next read data", rd_dato, 32'd8);
    rd_req = 1'b0;
    step;
    chk("read gap ack", 32'(rd_ack), 32'd0);

    // Reset during the third cycle of CLEAR with a read pending.
    clr = 1'b1;
    step;
    chk("abort c1 busy", 32'(busy), 32'd1);
    clr = 1'b0;
    step;
    step;
    chk("abort c3 busy", 32'(busy), 32'd1);
    rd_req = 1'b1;
    rd_dir = 3'd3;
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ack", 32'(rd_ack), 32'd0);
    chk("abort data", rd_dato, 32'd0);
    rd_req = 1'b0;
    sig = '0;
    o_sig = '0;
    step;
    step;
    rst = 1'b0;
    step;
    chk("post-reset ack", 32'(rd_ack), 32'd0);
    chk("post-reset busy", 32'(busy), 32'd0);
    rd(3'd3, 32'd0, "post-reset ch3");
    rd(3'd4, 32'd0, "post-reset ch4");

    // Overflow on the 4-bit instance: 14, 15, then overflow.
`ifdef PWR_CNTR_SAT_EN
    exp_sat1 = 4'hF;
    exp_sat2 = 4'hF;
`else
    exp_sat1 = 4'h0;
    exp_sat2 = 4'h1;
`endif
    for (int k = 0; k < 15; k++) begin
      o_sig[2] = ~o_sig[2];
      step;
    end
    chk("ovf at max", 32'(o_ovf), 32'd0);
    ord(3'd2, 4'hF, "ovf max");
    o_sig[2] = ~o_sig[2];
    step;
    chk("ovf set", 32'(o_ovf), 32'h4);
    ord(3'd2, exp_sat1, "ovf after wrap");
    o_sig[2] = ~o_sig[2];
    step;
    chk("ovf sticky", 32'(o_ovf), 32'h4);
    ord(3'd2, exp_sat2, "ovf next inc");
    o_clr = 1'b1;
    step;
    o_clr = 1'b0;
    for (int k = 0; k < 5; k++) step;
    chk("ovf clr busy", 32'(o_busy), 32'd0);
    chk("ovf cleared", 32'(o_ovf), 32'd0);
    ord(3'd2, 4'h0, "ovf cnt cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwr_cntr_bank.md
PWR_CNTR_BANK -- requirements
Module: pwr_cntr_bank

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NCH, 5: number of monitored channels; channel address range 0..NCH-1.
- AW, 3: address width.
- CW, 32: counter width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK: in, 1, single clock; all state changes on its rising edge.
- RST: in, 1, reset; asynchronous, active-high.
- ENB: in, 1, counting enable.
- SIG: in, NCH, monitored gate outputs (NOT, NAND, NOR, MUX, Q).
- CLR: in, 1, request to clear all counters.
- RD_REQ: in, 1, read request.
- RD_DIR: in, AW, read channel address.
- RD_DATO: out, CW, read data.
- RD_ACK: out, 1, read data valid.
- BUSY: out, 1, clear sequence in progress.
- OVF: out, NCH, per-channel overflow flag.

Function
REQ-003 The block SHALL register SIG into SIG_prev every cycle, regardless of ENB or state.
REQ-004 A channel SHALL register a toggle in a cycle when SIG[i] differs from SIG_prev[i].
REQ-005 In state IDLE with ENB=1, each channel with a toggle SHALL have its counter incremented by 1, with all channels updated in parallel in the same cycle.
REQ-006 With ENB=0, counters SHALL hold their values and toggles SHALL be discarded.
REQ-007 The FSM SHALL have exactly two states, IDLE and CLEAR.
REQ-008 CLR=1 sampled in IDLE SHALL move the FSM to CLEAR with clear index 0 on the next cycle.
REQ-009 In CLEAR:
- one counter (the indexed one) and its OVF bit SHALL be zeroed per cycle, in ascending index order;
- after index NCH-1 is cleared, the FSM SHALL return to IDLE;
- CLEAR SHALL therefore last exactly NCH cycles.
REQ-010 BUSY SHALL be 1 exactly while the state is CLEAR.
REQ-011 In CLEAR, no counter SHALL increment, and toggles occurring during CLEAR SHALL be lost.
REQ-012 CLR asserted while in CLEAR SHALL be ignored, with no restart and no extension of the sequence.
REQ-013 RD_REQ=1 with RD_DIR in cycle n SHALL produce RD_ACK=1 and RD_DATO equal to the counter value at the start of cycle n, both in cycle n+1.
REQ-014 RD_ACK SHALL be 1 for exactly one cycle per request cycle; back-to-back requests SHALL yield back-to-back acknowledges.
REQ-015 A read coinciding with an increment of the same channel SHALL return the pre-increment value.
REQ-016 A read with RD_DIR >= NCH SHALL return RD_ACK=1 and RD_DATO=0.
REQ-017 Reads SHALL be serviced in both IDLE and CLEAR, and a read during CLEAR SHALL return the current, possibly already-cleared, value.
REQ-018 RD_DATO SHALL be 0 in any cycle in which RD_ACK=0.
REQ-019 A counter at all-ones that receives an increment SHALL set its sticky OVF[i]; the counter value on that increment is defined in REQ-023.
REQ-020 OVF[i] SHALL be cleared only by reset or by CLEAR of channel i.

Reset
REQ-021 While RST=1, the block SHALL immediately force:
- all counters = 0;
- OVF = 0;
- SIG_prev = 0;
- state = IDLE, clear index = 0;
- BUSY = 0, RD_ACK = 0, RD_DATO = 0.
REQ-022 RST asserted mid-CLEAR or mid-read SHALL abort the operation, and no acknowledge SHALL follow the deassertion of RST.

Configuration
REQ-023 The macro PWR_CNTR_SAT_EN SHALL select overflow behaviour:
- defined: a counter at all-ones SHALL stay at all-ones (saturate) on further increments;
- undefined: a counter at all-ones SHALL wrap to 0 on the next increment;
- in both cases OVF[i] SHALL set as per REQ-019.

Verification
REQ-024 Scenario: reset, then ENB=1; SIG[0] toggles 10 times, one toggle per cycle; read RD_DIR=0 -> RD_DATO=10 one cycle after RD_REQ, RD_ACK pulses once.
REQ-025 Scenario: ENB=0, SIG[1] toggles 6 times; then ENB=1, SIG[1] toggles 4 times; read channel 1 -> 4.
REQ-026 Scenario: counts {3,5,7,9,11} on channels 0..4; pulse CLR -> BUSY=1 for exactly 5 cycles; a second CLR pulse during BUSY is ignored; all subsequent reads return 0.
REQ-027 Scenario: force counter 2 to 0xFFFFFFFE, then toggle SIG[2] twice -> OVF[2]=1; counter 2 reads 0xFFFFFFFF with PWR_CNTR_SAT_EN defined, 0x00000000 without it.
REQ-028 Scenario: read RD_DIR=5 -> RD_ACK=1, RD_DATO=0; read channel 3 in the same cycle it increments from 7 -> returns 7, and a next read returns 8.
REQ-029 Scenario: assert RST during the third cycle of CLEAR -> BUSY=0 immediately, all counters 0, no RD_ACK after release.
